mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: request address width in bits.
REQ-002 Parameter DATA_W, default 32: data width of all data buses in bits.
REQ-003 Single clock, synchronous active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ic_req  input  1  icache miss request; held high until ic_done.
REQ-007 ic_addr  input  ADDR_W  icache miss address; stable while ic_req is high.
REQ-008 ic_done  output  1  one-cycle pulse; ic_rdata is valid in the same cycle.
REQ-009 ic_rdata  output  DATA_W  read data returned to icache.
REQ-010 dc_req  input  1  dcache request; held high until dc_done.
REQ-011 dc_we  input  1  1 = write, 0 = read; stable while dc_req is high.
REQ-012 dc_addr  input  ADDR_W  dcache address; stable while dc_req is high.
REQ-013 dc_wdata  input  DATA_W  dcache write data.
REQ-014 dc_done  output  1  one-cycle pulse; dc_rdata is valid in the same cycle for reads.
REQ-015 dc_rdata  output  DATA_W  read data returned to dcache.
REQ-016 mem_req_valid  output  1  memory request valid.
REQ-017 mem_req_ready  input  1  memory accepts the request.
REQ-018 mem_rnw  output  1  1 = read, 0 = write.
REQ-019 mem_addr  output  ADDR_W  memory request address.
REQ-020 mem_wdata  output  DATA_W  memory write data.
REQ-021 mem_resp_valid  input  1  read response valid.
REQ-022 mem_resp_data  input  DATA_W  read response data.
REQ-023 stall  output  1  pipeline freeze to the core.

Function
REQ-024 FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
REQ-025 IDLE: on any request, latch the winner (owner, rnw, addr, wdata) and go to ISSUE next cycle.
REQ-026 Arbitration: fixed priority, dcache over icache, when both are high in the same IDLE cycle.
REQ-027 Loser handling: the losing request stays pending and is served immediately after the winner's DONE; no extra IDLE cycle is required before it is latched.
REQ-028 ISSUE: mem_req_valid=1 with the latched fields.
REQ-029 ISSUE hold: fields stay constant until mem_req_ready=1 (valid/ready handshake); mem_req_valid never drops before acceptance.
REQ-030 ISSUE exit on handshake: read goes to WAIT_RESP; write goes to DONE.
REQ-031 WAIT_RESP: mem_req_valid=0; on mem_resp_valid=1, capture mem_resp_data into the owner's rdata register and go to DONE.
REQ-032 Stray responses: mem_resp_valid in any state other than WAIT_RESP is ignored.
REQ-033 DONE: pulse the owner's done for exactly one cycle.
REQ-034 DONE exit: go to IDLE, or directly re-latch the pending other requester (REQ-027).
REQ-035 Re-latch rule: the same owner's req is not re-latched in its DONE cycle.
REQ-036 Minimum latency, read: req high to done pulse = 3 cycles, with ready and response each arriving the cycle after they are requested.
REQ-037 Minimum latency, write: req high to done pulse = 2 cycles.
REQ-038 rdata registers hold their last value until overwritten.
REQ-039 stall = (ic_req | dc_req | state != IDLE) & ~(last DONE cycle with no other request pending); combinational, so stall rises in the same cycle a req rises.
REQ-040 Owner pulses: ic_done and dc_done are never high in the same cycle.
REQ-041 Request withdrawal: a req deasserted after latch does not abort; the transaction completes and done still pulses.

Reset
REQ-042 On rst: state=IDLE; mem_req_valid=0, ic_done=0, dc_done=0, ic_rdata=0, dc_rdata=0; stall follows REQ-039 (0 when no req).
REQ-043 rst mid-transaction aborts it with no done pulse; a late mem_resp_valid after reset is ignored per REQ-032.

Verification
REQ-044 ic_req, addr 0x100, ready immediate, resp 0xDEADBEEF one cycle later -> mem_rnw=1, mem_addr=0x100; ic_done on cycle 3 with ic_rdata=0xDEADBEEF; stall high cycles 0-2.
REQ-045 ic_req and dc_req (write 0x200, 0x12345678) same cycle -> dcache write issued first, dc_done; then icache read issued with no IDLE gap; ic_done follows.
REQ-046 mem_req_ready held low 5 cycles -> mem_req_valid and fields constant all 5 cycles; single handshake; exactly one done.
REQ-047 rst asserted while in WAIT_RESP, then mem_resp_valid -> no done pulse; state IDLE; rdata unchanged at 0.
REQ-048 Back-to-back dc reads 0x10, 0x14 with no icache traffic -> two transactions, two dc_done pulses; second address appears only after the first DONE.
REQ-049 mem_resp_valid pulsed in IDLE -> no state change, no done, rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an icache (read-only) and a
// dcache (read/write) miss path.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   ic_req/ic_addr               icache read request (held until ic_done)
//   ic_done/ic_rdata             one-cycle completion pulse and read data
//   dc_req/dc_we/dc_addr/
//   dc_wdata                     dcache request (held until dc_done)
//   dc_done/dc_rdata             one-cycle completion pulse and read data
//   mem_req_valid/mem_req_ready  valid/ready request handshake to memory
//   mem_rnw/mem_addr/mem_wdata   latched request fields
//   mem_resp_valid/mem_resp_data read response from memory
//   stall                        pipeline freeze to the core
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              stall
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              own_dc_q, own_dc_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;

    logic do_latch;
    logic sel_dc;
    logic other_req;

    // Requester that does not own the current transaction.
    assign other_req = own_dc_q ? ic_req : dc_req;

    // Latch decision: IDLE takes anyone (dcache wins ties); DONE hands over
    // only to the other requester so the finishing owner is not re-latched.
    always_comb begin
        do_latch = 1'b0;
        sel_dc   = 1'b0;
        case (state_q)
            IDLE: begin
                do_latch = ic_req | dc_req;
                sel_dc   = dc_req;
            end
            DONE: begin
                do_latch = other_req;
                sel_dc   = ~own_dc_q;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        own_dc_d   = own_dc_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;

        case (state_q)
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = rnw_q ? WAIT_RESP : DONE;
                end
            end
            WAIT_RESP: begin
                // Responses outside this state are never captured.
                if (mem_resp_valid) begin
                    if (own_dc_q) begin
                        dc_rdata_d = mem_resp_data;
                    end else begin
                        ic_rdata_d = mem_resp_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
            end
        endcase

        if (do_latch) begin
            state_d  = ISSUE;
            own_dc_d = sel_dc;
            rnw_d    = sel_dc ? ~dc_we : 1'b1;
            addr_d   = sel_dc ? dc_addr : ic_addr;
            wdata_d  = sel_dc ? dc_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            own_dc_q   <= 1'b0;
            rnw_q      <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            own_dc_q   <= own_dc_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_rnw       = rnw_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign ic_done       = (state_q == DONE) & ~own_dc_q;
    assign dc_done       = (state_q == DONE) & own_dc_q;
    assign ic_rdata      = ic_rdata_q;
    assign dc_rdata      = dc_rdata_q;

    // Released in the final DONE cycle only when nobody else is waiting.
    assign stall = (ic_req | dc_req | (state_q != IDLE)) &
                   ~((state_q == DONE) & ~other_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level timing model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_done;
    logic [DW-1:0] ic_rdata;
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic          dc_done;
    logic [DW-1:0] dc_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_rnw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          stall;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_done       (ic_done),
        .ic_rdata      (ic_rdata),
        .dc_req        (dc_req),
        .dc_we         (dc_we),
        .dc_addr       (dc_addr),
        .dc_wdata      (dc_wdata),
        .dc_done       (dc_done),
        .dc_rdata      (dc_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_rnw       (mem_rnw),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge of the same cycle.
    task automatic drive_phase();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ic_req         = 1'b0;
        ic_addr        = '0;
        dc_req         = 1'b0;
        dc_we          = 1'b0;
        dc_addr        = '0;
        dc_wdata       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++;
            $display("FAIL reset.valid got=%b want=0", mem_req_valid); end
        total++; if (ic_done !== 1'b0 || dc_done !== 1'b0) begin bad++;
            $display("FAIL reset.done got=%b%b want=00", ic_done, dc_done); end
        total++; if (ic_rdata !== 32'h0 || dc_rdata !== 32'h0) begin bad++;
            $display("FAIL reset.rdata got=%h/%h want=0/0", ic_rdata, dc_rdata); end
        total++; if (stall !== 1'b0) begin bad++;
            $display("FAIL reset.stall_idle got=%b want=0", stall); end
        ic_req = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++;
            $display("FAIL reset.stall_req got=%b want=1", stall); end
        drive_phase();
        rst    = 1'b0;
        ic_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_phase();
        ic_req = 1'b1; ic_addr = 32'h80; mem_req_ready = 1'b1;
        @(negedge clk);
        drive_phase();
        @(negedge clk);
        drive_phase();
        mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (ic_done !== 1'b0) begin bad++;
            $display("FAIL reset_mid.done_in_wait got=%b want=0", ic_done); end
        for (int k = 0; k < 4; k++) begin
            drive_phase();
            rst = 1'b0; ic_req = 1'b0;
            mem_resp_valid = (k == 0);
            mem_resp_data  = 32'h1111_1111;
            @(negedge clk);
            total++; if (ic_done !== 1'b0 || dc_done !== 1'b0) begin bad++;
                $display("FAIL reset_mid.done[%0d] got=%b%b want=00", k, ic_done, dc_done); end
            total++; if (ic_rdata !== 32'h0) begin bad++;
                $display("FAIL reset_mid.rdata[%0d] got=%h want=0", k, ic_rdata); end
            total++; if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin bad++;
                $display("FAIL reset_mid.idle[%0d] valid=%b stall=%b want=0,0", k,
                         mem_req_valid, stall); end
        end
    endtask

    task automatic test_stray();
        for (int k = 0; k < 4; k++) begin
            drive_phase();
            mem_resp_valid = (k < 3);
            mem_resp_data  = $urandom;
            @(negedge clk);
            total++; if (ic_done !== 1'b0 || dc_done !== 1'b0) begin bad++;
                $display("FAIL stray.done[%0d] got=%b%b want=00", k, ic_done, dc_done); end
            total++; if (ic_rdata !== 32'h0 || dc_rdata !== 32'h0) begin bad++;
                $display("FAIL stray.rdata[%0d] got=%h/%h want=0/0", k, ic_rdata, dc_rdata); end
            total++; if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin bad++;
                $display("FAIL stray.idle[%0d] valid=%b stall=%b want=0,0", k,
                         mem_req_valid, stall); end
        end
    endtask

    task automatic test_ic_read();
        drive_phase();
        ic_req = 1'b1; ic_addr = 32'h100; mem_req_ready = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin bad++;
            $display("FAIL ic_read.c0 stall=%b valid=%b want=1,0", stall, mem_req_valid); end
        drive_phase();
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1 || mem_rnw !== 1'b1 || mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL ic_read.issue valid=%b rnw=%b addr=%h want=1,1,100",
                     mem_req_valid, mem_rnw, mem_addr); end
        total++; if (stall !== 1'b1) begin bad++;
            $display("FAIL ic_read.stall_c1 got=%b want=1", stall); end
        drive_phase();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0 || stall !== 1'b1 || ic_done !== 1'b0) begin bad++;
            $display("FAIL ic_read.wait valid=%b stall=%b done=%b want=0,1,0",
                     mem_req_valid, stall, ic_done); end
        drive_phase();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (ic_done !== 1'b1 || dc_done !== 1'b0) begin bad++;
            $display("FAIL ic_read.done got=%b%b want=10", ic_done, dc_done); end
        total++; if (ic_rdata !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL ic_read.rdata got=%h want=deadbeef", ic_rdata); end
        total++; if (stall !== 1'b0) begin bad++;
            $display("FAIL ic_read.stall_done got=%b want=0", stall); end
        drive_phase();
        ic_req = 1'b0;
        @(negedge clk);
        total++; if (ic_done !== 1'b0 || stall !== 1'b0) begin bad++;
            $display("FAIL ic_read.after done=%b stall=%b want=0,0", ic_done, stall); end
    endtask

    task automatic test_both();
        drive_phase();
        ic_req = 1'b1; ic_addr = 32'h300;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h200; dc_wdata = 32'h1234_5678;
        mem_req_ready = 1'b1;
        @(negedge clk);
        drive_phase();
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1 || mem_rnw !== 1'b0 || mem_addr !== 32'h200 ||
                     mem_wdata !== 32'h1234_5678) begin bad++;
            $display("FAIL both.dc_first valid=%b rnw=%b addr=%h wdata=%h want=1,0,200,12345678",
                     mem_req_valid, mem_rnw, mem_addr, mem_wdata); end
        drive_phase();
        @(negedge clk);
        total++; if (dc_done !== 1'b1 || ic_done !== 1'b0 || stall !== 1'b1) begin bad++;
            $display("FAIL both.dc_done dc=%b ic=%b stall=%b want=1,0,1",
                     dc_done, ic_done, stall); end
        drive_phase();
        dc_req = 1'b0;
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1 || mem_rnw !== 1'b1 || mem_addr !== 32'h300) begin
            bad++;
            $display("FAIL both.ic_no_gap valid=%b rnw=%b addr=%h want=1,1,300",
                     mem_req_valid, mem_rnw, mem_addr); end
        drive_phase();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
        @(negedge clk);
        drive_phase();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (ic_done !== 1'b1 || dc_done !== 1'b0 || ic_rdata !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL both.ic_done ic=%b dc=%b rdata=%h want=1,0,cafef00d",
                     ic_done, dc_done, ic_rdata); end
        drive_phase();
        ic_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ready_hold();
        int n_valid = 0;
        int n_done  = 0;
        drive_phase();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h40; mem_req_ready = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            drive_phase();
            @(negedge clk);
            total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40 || mem_rnw !== 1'b1) begin
                bad++;
                $display("FAIL ready_hold.hold[%0d] valid=%b addr=%h rnw=%b want=1,40,1",
                         k, mem_req_valid, mem_addr, mem_rnw); end
        end
        drive_phase();
        mem_req_ready = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            drive_phase();
            mem_req_ready  = 1'b0;
            mem_resp_valid = (j == 0);
            mem_resp_data  = 32'h55AA_55AA;
            if (j == 2) dc_req = 1'b0;
            @(negedge clk);
            if (mem_req_valid) n_valid++;
            if (dc_done) n_done++;
        end
        total++; if (n_valid !== 0) begin bad++;
            $display("FAIL ready_hold.extra_issue got=%0d want=0", n_valid); end
        total++; if (n_done !== 1) begin bad++;
            $display("FAIL ready_hold.done_count got=%0d want=1", n_done); end
        total++; if (dc_rdata !== 32'h55AA_55AA) begin bad++;
            $display("FAIL ready_hold.rdata got=%h want=55aa55aa", dc_rdata); end
    endtask

    task automatic test_back_to_back();
        drive_phase();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h10; mem_req_ready = 1'b1;
        @(negedge clk);
        drive_phase();
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h10) begin bad++;
            $display("FAIL b2b.first valid=%b addr=%h want=1,10", mem_req_valid, mem_addr); end
        drive_phase();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0A0A_0A0A;
        @(negedge clk);
        drive_phase();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (dc_done !== 1'b1 || dc_rdata !== 32'h0A0A_0A0A || stall !== 1'b0) begin
            bad++;
            $display("FAIL b2b.done1 done=%b rdata=%h stall=%b want=1,0a0a0a0a,0",
                     dc_done, dc_rdata, stall); end
        drive_phase();
        dc_addr = 32'h14; mem_req_ready = 1'b1;
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b0 || dc_done !== 1'b0 || stall !== 1'b1) begin bad++;
            $display("FAIL b2b.idle_gap valid=%b done=%b stall=%b want=0,0,1",
                     mem_req_valid, dc_done, stall); end
        drive_phase();
        @(negedge clk);
        total++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h14) begin bad++;
            $display("FAIL b2b.second valid=%b addr=%h want=1,14", mem_req_valid, mem_addr); end
        drive_phase();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1414_1414;
        @(negedge clk);
        drive_phase();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (dc_done !== 1'b1 || dc_rdata !== 32'h1414_1414) begin bad++;
            $display("FAIL b2b.done2 done=%b rdata=%h want=1,14141414", dc_done, dc_rdata); end
        drive_phase();
        dc_req = 1'b0;
        @(negedge clk);
    endtask

    // Randomized traffic. The model tracks one transaction at a time by its
    // key cycle numbers: issue start, handshake, response and done.
    task automatic test_random();
        bit          busy = 1'b0;
        bit          own_dc = 1'b0;
        bit          hs = 1'b0;
        bit          m_rnw = 1'b1;
        bit          ic_fin = 1'b0;
        bit          dc_fin = 1'b0;
        bit          e_valid, e_icd, e_dcd, e_stall, other, do_l, sel;
        logic [31:0] m_addr = '0;
        logic [31:0] m_wdata = '0;
        logic [31:0] exp_ic = '0;
        logic [31:0] exp_dc = '0;
        logic [31:0] rd = '0;
        int          start = 0;
        int          done_c = -1;
        int          resp_c = -1;
        int          d;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_phase();
            if (ic_fin) begin ic_req = 1'b0; ic_fin = 1'b0; end
            if (dc_fin) begin dc_req = 1'b0; dc_fin = 1'b0; end
            if (!ic_req && $urandom_range(0, 2) == 0) begin
                ic_req = 1'b1; ic_addr = $urandom;
            end
            if (!dc_req && $urandom_range(0, 2) == 0) begin
                dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1));
                dc_addr = $urandom; dc_wdata = $urandom;
            end
            mem_req_ready = ($urandom_range(0, 2) != 0);
            if (c == resp_c) begin
                mem_resp_valid = 1'b1; mem_resp_data = rd;
            end else if (resp_c > c) begin
                mem_resp_valid = 1'b0;
            end else begin
                mem_resp_valid = ($urandom_range(0, 3) == 0); mem_resp_data = $urandom;
            end
            @(negedge clk);

            e_valid = busy && c >= start && !hs;
            e_icd   = busy && c == done_c && !own_dc;
            e_dcd   = busy && c == done_c && own_dc;
            other   = own_dc ? ic_req : dc_req;
            e_stall = (ic_req || dc_req || (busy && c >= start)) &&
                      !(busy && c == done_c && !other);
            total++; if (mem_req_valid !== e_valid) begin bad++;
                $display("FAIL rand.valid c=%0d got=%b want=%b", c, mem_req_valid, e_valid); end
            if (e_valid) begin
                total++; if (mem_rnw !== m_rnw || mem_addr !== m_addr ||
                             (!m_rnw && mem_wdata !== m_wdata)) begin bad++;
                    $display("FAIL rand.fields c=%0d got=%b,%h,%h want=%b,%h,%h", c,
                             mem_rnw, mem_addr, mem_wdata, m_rnw, m_addr, m_wdata); end
            end
            total++; if (ic_done !== e_icd || dc_done !== e_dcd) begin bad++;
                $display("FAIL rand.done c=%0d got=%b%b want=%b%b", c,
                         ic_done, dc_done, e_icd, e_dcd); end
            total++; if (stall !== e_stall) begin bad++;
                $display("FAIL rand.stall c=%0d got=%b want=%b", c, stall, e_stall); end
            total++; if (ic_rdata !== exp_ic || dc_rdata !== exp_dc) begin bad++;
                $display("FAIL rand.rdata c=%0d got=%h/%h want=%h/%h", c,
                         ic_rdata, dc_rdata, exp_ic, exp_dc); end

            if (c == resp_c) begin
                if (own_dc) exp_dc = rd; else exp_ic = rd;
                resp_c = -1;
            end
            if (e_valid && mem_req_ready) begin
                hs = 1'b1;
                if (m_rnw) begin
                    d      = $urandom_range(0, 3);
                    resp_c = c + 1 + d;
                    rd     = $urandom;
                    done_c = c + 2 + d;
                end else begin
                    done_c = c + 1;
                end
            end
            do_l = 1'b0;
            sel  = 1'b0;
            if (busy && c == done_c) begin
                busy = 1'b0;
                if (own_dc) dc_fin = 1'b1; else ic_fin = 1'b1;
                do_l = other;
                sel  = !own_dc;
            end else if (!busy && (ic_req || dc_req)) begin
                do_l = 1'b1;
                sel  = dc_req;
            end
            if (do_l) begin
                busy    = 1'b1;
                own_dc  = sel;
                m_rnw   = sel ? !dc_we : 1'b1;
                m_addr  = sel ? dc_addr : ic_addr;
                m_wdata = dc_wdata;
                start   = c + 1;
                hs      = 1'b0;
                done_c  = -1;
            end
        end
        drive_phase();
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_reset_mid();
        test_stray();
        test_ic_read();
        test_both();
        test_ready_hold();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
